// File: rtl/imul_pipe_pkg.sv
// imul_pipe shared types: mode encodings,
// flag bit positions and the per-op control bundle.
package imul_pipe_pkg;

  typedef enum logic [2:0] {
    MUL_LO_U  = 3'd0,
    MUL_LO_S  = 3'd1,
    MUL_HI_U  = 3'd2,
    MUL_HI_S  = 3'd3,
    MUL_HI_SU = 3'd4
  } mode_e;

  localparam int FLG_PF  = 0;
  localparam int FLG_ZF  = 1;
  localparam int FLG_SF  = 2;
  localparam int FLG_RSV = 3;
  localparam int FLG_OF  = 4;
  localparam int FLG_CF  = 5;

  // Tag field is sized for the widest tag any user needs.
  localparam int CTL_TAG_W = 16;

  typedef struct packed {
    logic [2:0]           mode;
    logic                 short_op;
    logic [CTL_TAG_W-1:0] tag;
  } ctl_t;

  function automatic logic a_signed(logic [2:0] m);
    return (m == MUL_LO_S) || (m == MUL_HI_S) ||
           (m == MUL_HI_SU);
  endfunction

  function automatic logic b_signed(logic [2:0] m);
    return (m == MUL_LO_S) || (m == MUL_HI_S);
  endfunction

endpackage

// File: rtl/imul_pipe_if.sv
// imul_pipe issue/return bus.
// master drives ops, slave is the multiplier.
interface imul_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 9
);
  logic             clkEn;
  logic             flush;
  logic             in_valid;
  logic [2:0]       in_mode;
  logic             in_short;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [WIDTH-1:0] out_res;
  logic [5:0]       out_flg;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output clkEn, flush, in_valid, in_mode,
    output in_short, in_a, in_b, in_tag,
    input  out_valid, out_res, out_flg, out_tag
  );

  modport slave (
    input  clkEn, flush, in_valid, in_mode,
    input  in_short, in_a, in_b, in_tag,
    output out_valid, out_res, out_flg, out_tag
  );
endinterface

// File: rtl/imul_flags.sv
// imul_flags: result-half select and flags
// from a full product, mode and short flag.
module imul_flags
  import imul_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] p_i,
  input  logic [2:0]         mode_i,
  input  logic               short_i,
  output logic [WIDTH-1:0]   res_o,
  output logic [5:0]         flg_o
);
  localparam int PW = 2 * WIDTH;
  localparam int HW = WIDTH / 2;

  logic hi_sel, sgn, rsv, ovf;
  logic [PW-1:WIDTH-1]  top_f;
  logic [WIDTH-1:HW-1]  top_s;

  assign top_f = p_i[PW-1:WIDTH-1];
  assign top_s = p_i[WIDTH-1:HW-1];

  // Decode mode; reserved codes act as unsigned low.
  always_comb begin
    hi_sel = 1'b0;
    sgn    = 1'b0;
    rsv    = 1'b0;
    case (mode_i)
      MUL_LO_U:  ;
      MUL_LO_S:  sgn = 1'b1;
      MUL_HI_U,
      MUL_HI_S,
      MUL_HI_SU: hi_sel = 1'b1;
      default:   rsv = 1'b1;
    endcase
  end

  // Overflow of the low half, plus result select and flags.
  always_comb begin
    ovf   = 1'b0;
    res_o = '0;
    flg_o = '0;
    if (short_i) begin
      ovf = sgn ? !((&top_s) || !(|top_s))
                : |p_i[WIDTH-1:HW];
      res_o[HW-1:0] = hi_sel ? p_i[WIDTH-1:HW]
                             : p_i[HW-1:0];
      flg_o[FLG_SF] = res_o[HW-1];
      flg_o[FLG_ZF] = (res_o[HW-1:0] == '0);
    end else begin
      ovf = sgn ? !((&top_f) || !(|top_f))
                : |p_i[PW-1:WIDTH];
      res_o = hi_sel ? p_i[PW-1:WIDTH]
                     : p_i[WIDTH-1:0];
      flg_o[FLG_SF] = res_o[WIDTH-1];
      flg_o[FLG_ZF] = (res_o == '0);
    end
    flg_o[FLG_PF] = ~^res_o[7:0];
    flg_o[FLG_CF] = rsv | (~hi_sel & ovf);
    flg_o[FLG_OF] = rsv | (~hi_sel & ovf);
  end
endmodule

// File: rtl/imul_pipe.sv
// imul_pipe: parametrised pipelined integer
// multiplier with tag tracking and flush.
module imul_pipe
  import imul_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 9
) (
  input logic       clk,
  input logic       rst,
  imul_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int HW = WIDTH / 2;

  logic          as_d, bs_d;
  logic [PW-1:0] a_d, b_d, a_q, b_q;
  ctl_t          ctl_d;
  ctl_t          ctl_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [PW-1:0] p_q [1:STAGES-1];

  logic [WIDTH-1:0] res_d;
  logic [5:0]       flg_d;
  logic             ov_q;
  logic [WIDTH-1:0] ores_q;
  logic [5:0]       oflg_q;
  logic [TAG_W-1:0] otag_q;

  // Extend operands from n bits to 2*WIDTH.
  always_comb begin
    as_d = a_signed(bus.in_mode);
    bs_d = b_signed(bus.in_mode);
    if (bus.in_short) begin
      a_d = {{(PW-HW){as_d & bus.in_a[HW-1]}},
             bus.in_a[HW-1:0]};
      b_d = {{(PW-HW){bs_d & bus.in_b[HW-1]}},
             bus.in_b[HW-1:0]};
    end else begin
      a_d = {{WIDTH{as_d & bus.in_a[WIDTH-1]}},
             bus.in_a};
      b_d = {{WIDTH{bs_d & bus.in_b[WIDTH-1]}},
             bus.in_b};
    end
    ctl_d.mode     = bus.in_mode;
    ctl_d.short_op = bus.in_short;
    ctl_d.tag      = CTL_TAG_W'(bus.in_tag);
  end

  // Valid shift chain; flush kills every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (bus.clkEn) begin
      if (bus.flush) vld_q <= '0;
      else vld_q <= {vld_q[STAGES-2:0], bus.in_valid};
    end
  end

  // Operands, control and product pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < STAGES; i++) ctl_q[i] <= '0;
      for (int k = 1; k < STAGES; k++) p_q[k] <= '0;
    end else if (bus.clkEn) begin
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q[0] <= ctl_d;
      for (int i = 1; i < STAGES; i++)
        ctl_q[i] <= ctl_q[i-1];
      p_q[1] <= a_q * b_q;
      for (int k = 2; k < STAGES; k++)
        p_q[k] <= p_q[k-1];
    end
  end

  imul_flags #(.WIDTH(WIDTH)) u_flags (
    .p_i     (p_q[STAGES-1]),
    .mode_i  (ctl_q[STAGES-1].mode),
    .short_i (ctl_q[STAGES-1].short_op),
    .res_o   (res_d),
    .flg_o   (flg_d)
  );

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      ores_q <= '0;
      oflg_q <= '0;
      otag_q <= '0;
    end else if (bus.clkEn) begin
      ov_q   <= vld_q[STAGES-1] & ~bus.flush;
      ores_q <= res_d;
      oflg_q <= flg_d;
      otag_q <= TAG_W'(ctl_q[STAGES-1].tag);
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_res   = ores_q;
  assign bus.out_flg   = oflg_q;
  assign bus.out_tag   = otag_q;
endmodule

// File: tb/tb_imul_pipe.sv
// tb_imul_pipe: directed checks of imul_pipe
// latency, data, flags, stalls, flush and reset.
module tb_imul_pipe;
  localparam int W = 64;
  localparam int S = 3;
  localparam int T = 9;

  logic clk;
  logic rst;
  int   npass;
  int   ntot;
  int   ei;
  int   got_tag [$];
  int   got_ei  [$];

  imul_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

  imul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h",
                nm, obs, exp);
  endtask

  // Apply inputs for one cycle, take the edge, sample at +1.
  task automatic step(input logic en, input logic v,
                      input logic fl, input int tag);
    bus.clkEn    = en;
    bus.in_valid = v;
    bus.flush    = fl;
    bus.in_tag   = T'(tag);
    @(posedge clk);
    #1;
    if (en) begin
      if (bus.out_valid) begin
        got_tag.push_back(int'(bus.out_tag));
        got_ei.push_back(ei);
      end
      ei++;
    end
  endtask

  task automatic run_op(input string nm,
                        input logic [2:0] md,
                        input logic sh,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input int tag,
                        input logic [63:0] er,
                        input logic [5:0] ef);
    bus.in_mode  = md;
    bus.in_short = sh;
    bus.in_a     = a;
    bus.in_b     = b;
    step(1'b1, 1'b1, 1'b0, tag);
    for (int i = 0; i < S - 1; i++)
      step(1'b1, 1'b0, 1'b0, 0);
    chk({nm, "_early"}, 64'(bus.out_valid), 64'd0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk({nm, "_vld"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_res"}, bus.out_res, er);
    chk({nm, "_flg"}, 64'(bus.out_flg), 64'(ef));
    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
  endtask

  initial begin
    npass        = 0;
    ntot         = 0;
    ei           = 0;
    rst          = 1'b1;
    bus.clkEn    = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mode  = 3'd0;
    bus.in_short = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_tag   = '0;
    #12;
    chk("rst_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_res", bus.out_res, 64'd0);
    chk("rst_flg", 64'(bus.out_flg), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("lo_u", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, 6'b110100);
    run_op("lo_s", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD,
           64'd5, 34, 64'hFFFF_FFFF_FFFF_FFF1, 6'b000100);
    run_op("hi_s", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 35, 64'd0, 6'b000011);
    run_op("hi_su", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd2, 36, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000101);
    run_op("hi_u", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 37,
           64'hFFFF_FFFF_FFFF_FFFE, 6'b000100);
    run_op("short_s", 3'd1, 1'b1, 64'h0000_0000_8000_0000,
           64'd2, 38, 64'd0, 6'b110011);
    run_op("rsvd", 3'd5, 1'b0, 64'd3, 64'd4, 39,
           64'd12, 6'b110001);

    // Back-to-back stream with a 2-cycle stall.
    bus.in_mode  = 3'd0;
    bus.in_short = 1'b0;
    got_tag.delete();
    got_ei.delete();
    ei = 0;
    for (int t = 1; t <= 5; t++)
      step(1'b1, 1'b1, 1'b0, t);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 99);
      chk("stall_vld", 64'(bus.out_valid), 64'd1);
      chk("stall_tag", 64'(bus.out_tag), 64'd2);
    end
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 0);
    chk("b2b_cnt", 64'(got_tag.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_tag.size()) begin
        chk("b2b_tag", 64'(got_tag[k]), 64'(k + 1));
        chk("b2b_ei", 64'(got_ei[k]), 64'(k + 3));
      end
    end

    // Flush kills 7,8,9,10; 11 and 12 survive.
    got_tag.delete();
    got_ei.delete();
    ei = 0;
    step(1'b1, 1'b1, 1'b0, 7);
    step(1'b1, 1'b1, 1'b0, 8);
    step(1'b1, 1'b1, 1'b0, 9);
    step(1'b1, 1'b1, 1'b1, 10);
    step(1'b1, 1'b1, 1'b0, 11);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 12);
    step(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, 0);
    chk("fl_cnt", 64'(got_tag.size()), 64'd2);
    if (got_tag.size() == 2) begin
      chk("fl_tag0", 64'(got_tag[0]), 64'd11);
      chk("fl_ei0", 64'(got_ei[0]), 64'd7);
      chk("fl_tag1", 64'(got_tag[1]), 64'd12);
      chk("fl_ei1", 64'(got_ei[1]), 64'd11);
    end

    // Asynchronous reset with ops in flight.
    bus.in_a = 64'd6;
    bus.in_b = 64'd7;
    for (int t = 20; t < 24; t++)
      step(1'b1, 1'b1, 1'b0, t);
    chk("pre_rst_vld", 64'(bus.out_valid), 64'd1);
    chk("pre_rst_res", bus.out_res, 64'd42);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(bus.out_valid), 64'd0);
    chk("arst_res", bus.out_res, 64'd0);
    chk("arst_flg", 64'(bus.out_flg), 64'd0);
    chk("arst_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    got_tag.delete();
    got_ei.delete();
    ei = 0;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 0);
    chk("post_rst_cnt", 64'(got_tag.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
